// File: rtl/sym_modulator.sv
// ============================================================================
//  Module   : sym_modulator
//  Brief    : Keys a 16-bit offset-binary carrier per data bit (BPSK/ASK/OOK/
//             pass-through), holding each bit for SAMPLES_PER_SYMBOL samples.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sym_modulator #(
  parameter int SAMPLES_PER_SYMBOL = 64,
  parameter int CNT_W              = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] carrier_in,
  input  logic [1:0]  mode,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic [15:0] mod_out,
  output logic        mod_valid,
  output logic        sym_start,
  output logic        busy
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [1:0]       c_mode_bpsk = 2'b00;
  localparam logic [1:0]       c_mode_ask  = 2'b01;
  localparam logic [1:0]       c_mode_ook  = 2'b10;
  localparam logic [15:0]      c_midscale  = 16'h8000;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cur_bit;
  logic [1:0]       r_cur_mode;
  logic [15:0]      r_mod_out;
  logic             r_mod_valid;
  logic             r_sym_start;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cur_bit_nxt;
  logic [1:0]       w_cur_mode_nxt;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;
  logic [15:0]      w_centered;
  logic [15:0]      w_ask_half;
  logic [15:0]      w_sample;

  assign w_last   = (r_cnt == c_last_cnt);
  assign w_ready  = (r_state == S_IDLE) || ((r_state == S_ACTIVE) && w_last);
  assign w_accept = bit_valid && w_ready;

  // Flipping the MSB converts offset binary to two's complement and back,
  // so the half-amplitude ASK level is an arithmetic shift in between.
  assign w_centered = carrier_in ^ c_midscale;
  assign w_ask_half = {w_centered[15], w_centered[15:1]} ^ c_midscale;

  always_comb begin
    w_sample = carrier_in;
    case (r_cur_mode)
      c_mode_bpsk: if (!r_cur_bit) w_sample = ~carrier_in;
      c_mode_ask:  if (!r_cur_bit) w_sample = w_ask_half;
      c_mode_ook:  if (!r_cur_bit) w_sample = c_midscale;
      default:     w_sample = carrier_in;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_cur_bit_nxt  = r_cur_bit;
    w_cur_mode_nxt = r_cur_mode;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt    = S_ACTIVE;
          w_cnt_nxt      = '0;
          w_cur_bit_nxt  = bit_in;
          w_cur_mode_nxt = mode;
        end
      end
      S_ACTIVE: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          if (w_accept) begin
            w_cur_bit_nxt  = bit_in;
            w_cur_mode_nxt = mode;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cur_bit  <= 1'b0;
      r_cur_mode <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cur_bit  <= w_cur_bit_nxt;
      r_cur_mode <= w_cur_mode_nxt;
    end
  end

  // Output stage lags the symbol state by one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mod_out   <= c_midscale;
      r_mod_valid <= 1'b0;
      r_sym_start <= 1'b0;
    end else if (r_state == S_ACTIVE) begin
      r_mod_out   <= w_sample;
      r_mod_valid <= 1'b1;
      r_sym_start <= (r_cnt == '0);
    end else begin
      r_mod_out   <= c_midscale;
      r_mod_valid <= 1'b0;
      r_sym_start <= 1'b0;
    end
  end

  assign bit_ready = w_ready;
  assign mod_out   = r_mod_out;
  assign mod_valid = r_mod_valid;
  assign sym_start = r_sym_start;
  assign busy      = (r_state == S_ACTIVE);

endmodule

`default_nettype wire

// File: doc/sym_modulator.md
# sym_modulator

Digital baseband modulation stage directly downstream of `sine_gen`. It consumes the 16-bit carrier samples from `sine_gen.wave_out` and a serial data-bit stream delivered over a valid/ready handshake. Each bit is held for a fixed number of carrier samples, and the carrier is keyed per bit as BPSK, ASK or OOK. The registered, modulated sample stream goes to the DAC interface.

## Interface
Parameters:
- `SAMPLES_PER_SYMBOL`, default 64: carrier samples emitted per data bit; legal range 2..4096.
- `CNT_W`, default 12: symbol counter width; must satisfy 2^CNT_W >= SAMPLES_PER_SYMBOL.

Ports:
- `clk`  in  1: single clock, same domain as `sine_gen`.
- `reset`  in  1: synchronous, active-high.
- `carrier_in`  in  16: carrier sample, unsigned offset binary; midscale 16'h8000. Valid every cycle.
- `mode`  in  2: 00 BPSK, 01 ASK, 10 OOK, 11 pass-through.
- `bit_in`  in  1: data bit.
- `bit_valid`  in  1: `bit_in` is valid.
- `bit_ready`  out  1: block accepts a bit this cycle.
- `mod_out`  out  16: modulated sample, unsigned offset binary.
- `mod_valid`  out  1: `mod_out` is a live sample.
- `sym_start`  out  1: one-cycle pulse, coincident with the first sample of each symbol.
- `busy`  out  1: a symbol is in progress (state ACTIVE).

## Operation
- States:
  - IDLE: no symbol in progress.
  - ACTIVE: holds the current bit `cur_bit`, the current mode `cur_mode` and the counter `cnt` (0..SPS-1).
- Handshake: a transfer occurs on any edge where `bit_valid && bit_ready`.
  - `bit_ready = (state==IDLE) || (state==ACTIVE && cnt==SPS-1)`.
  - `bit_ready` is combinational and never depends on `bit_valid`.
- IDLE, on transfer: latch `cur_bit <= bit_in` and `cur_mode <= mode`, set `cnt <= 0`, go to ACTIVE.
- ACTIVE, each cycle: emit one sample, then `cnt <= cnt+1`. When `cnt==SPS-1`:
  - transfer present: latch the new bit and mode, `cnt <= 0`, stay ACTIVE (gapless).
  - no transfer: go to IDLE.
- `mode` is sampled only at bit latch. Changes mid-symbol are ignored until the next symbol.
- Sample function, with c = `carrier_in`:
  - BPSK: bit 1 → c; bit 0 → ~c. This is a bitwise inversion, i.e. 16'hFFFF − c, mirrored about midscale.
  - ASK: bit 1 → c; bit 0 → ((c − 16'h8000) as signed 16, arithmetic shift right 1) + 16'h8000. This is half amplitude about midscale, computed with no overflow.
  - OOK: bit 1 → c; bit 0 → 16'h8000.
  - Pass-through: always c; the bit is ignored.
- Output in IDLE: `mod_out` = 16'h8000, `mod_valid` = 0, `sym_start` = 0.
- Reset values: state IDLE, `cnt` 0, `cur_bit` 0, `cur_mode` 00, `mod_out` 16'h8000, `mod_valid` 0, `sym_start` 0, `busy` 0. `bit_ready` reads 1 from the first cycle after reset.
- Reset mid-symbol: the symbol is abandoned and no further samples are emitted. The bit being processed is dropped and is not re-requested.

## Timing
- `mod_out`, `mod_valid` and `sym_start` are registered.
  - A sample emitted in ACTIVE cycle k uses `carrier_in` as seen during cycle k.
  - That sample appears on `mod_out` after edge k+1.
- Handshake accepted at edge E0:
  - ACTIVE from E0.
  - First sample, with `mod_valid=1` and `sym_start=1`, is visible after E1.
  - The last sample of the symbol is visible after E(SPS).
- Back-to-back symbols: `mod_valid` stays high continuously. `sym_start` pulses every SPS cycles.
- After the final symbol with no new bit: `mod_valid` drops to 0 and `mod_out` returns to 16'h8000 one cycle after the last sample.
- `busy` is registered and equals (state==ACTIVE).
- `cnt` wraps only via the SPS-1 comparison. It never overflows CNT_W.

## Test plan
- Reset: assert `reset` for 3 cycles with `bit_valid=1`.
  - Required: no transfer, `mod_out`=16'h8000, `mod_valid`=0, `bit_ready`=1 after release.
- BPSK single bit 0, SPS=4, carrier ramp 16'h9000, 16'hA000, 16'hB000, 16'hC000.
  - Required: `mod_out` = 16'h6FFF, 16'h5FFF, 16'h4FFF, 16'h3FFF on 4 consecutive cycles with `sym_start` on the first.
  - Then `mod_valid`=0 and `mod_out`=16'h8000.
- Back-to-back bits 1,0,1 in ASK with `bit_valid` held high, SPS=8.
  - Required: 24 contiguous valid samples, `sym_start` at samples 0, 8 and 16.
  - Middle symbol: carrier 16'hC000 → 16'hA000, carrier 16'h0000 → 16'h4000.
- OOK bit 0, then a mode change to BPSK mid-symbol.
  - Required: all SPS samples are 16'h8000. The new mode takes effect only on the next bit.
- Reset asserted at `cnt`=3 of an 8-sample symbol.
  - Required: `mod_valid`=0 the next cycle and the state is IDLE. The next accepted bit starts a fresh symbol with `sym_start`.
- Stall: `bit_valid` drops for 5 cycles between symbols.
  - Required: `mod_valid` low for exactly 5 cycles.
  - `bit_ready` stays high throughout the gap. In ACTIVE it is high only when `cnt`=SPS-1.
